// File: rtl/qosc_config_loader.sv
// Byte-serial loader for the quadrature oscillator preload words.
// Assembles a checksummed frame in shadow registers and commits it atomically with a load strobe.
module qosc_config_loader #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned TIMEOUT     = 1023,
    parameter int unsigned LOAD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic [WIDTH-1:0] re_coeff,
    output logic [WIDTH-1:0] im_coeff,
    output logic [WIDTH-1:0] power,
    output logic [WIDTH-1:0] accu_re_init,
    output logic [WIDTH-1:0] accu_im_init,
    output logic             load,
    output logic             err_checksum,
    output logic             err_timeout,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned NBYTES = 10;
    localparam int unsigned SH_W   = 8 * NBYTES;
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned LC_W   = 4;
    localparam int unsigned IDX_W  = 4;
    localparam logic [7:0]  HEADER = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK,
        S_LOAD
    } state_t;

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic             load_q, load_d;
    logic             errc_q, errc_d;
    logic             errt_q, errt_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic [7:0]       csum_q, csum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [LC_W-1:0]  lcnt_q, lcnt_d;
    logic [SH_W-1:0]  shadow_q, shadow_d;
    logic [WIDTH-1:0] re_q, re_d, im_q, im_d, pw_q, pw_d, ar_q, ar_d, ai_q, ai_d;
    logic             accept;
    logic             to_expire;

    assign accept    = data_valid && ready_q;
    assign to_expire = (to_q == TO_W'(TIMEOUT - 1));

    // Next-state logic; shadow is a shift register so byte 0 (re_coeff MSB) lands at the top
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        load_d   = load_q;
        errc_d   = errc_q;
        errt_d   = errt_q;
        fcnt_d   = fcnt_q;
        csum_d   = csum_q;
        idx_d    = idx_q;
        to_d     = to_q;
        lcnt_d   = lcnt_q;
        shadow_d = shadow_q;
        re_d     = re_q;
        im_d     = im_q;
        pw_d     = pw_q;
        ar_d     = ar_q;
        ai_d     = ai_q;

        case (state_q)
            S_IDLE: begin
                if (accept && data_in == HEADER) begin
                    errc_d  = 1'b0;
                    errt_d  = 1'b0;
                    csum_d  = 8'h00;
                    idx_d   = '0;
                    to_d    = '0;
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    shadow_d = {shadow_q[SH_W-9:0], data_in};
                    csum_d   = csum_q ^ data_in;
                    idx_d    = idx_q + IDX_W'(1);
                    to_d     = '0;
                    if (idx_q == IDX_W'(NBYTES - 1)) begin
                        state_d = S_CHECK;
                    end
                end else if (to_expire) begin
                    errt_d  = 1'b1;
                    to_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_CHECK: begin
                if (accept) begin
                    to_d = '0;
                    if (data_in == csum_q) begin
                        re_d    = WIDTH'(shadow_q[79:64]);
                        im_d    = WIDTH'(shadow_q[63:48]);
                        pw_d    = WIDTH'(shadow_q[47:32]);
                        ar_d    = WIDTH'(shadow_q[31:16]);
                        ai_d    = WIDTH'(shadow_q[15:0]);
                        load_d  = 1'b1;
                        ready_d = 1'b0;
                        fcnt_d  = fcnt_q + 8'd1;
                        lcnt_d  = LC_W'(1);
                        state_d = S_LOAD;
                    end else begin
                        errc_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (to_expire) begin
                    errt_d  = 1'b1;
                    to_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_LOAD: begin
                if (lcnt_q == LC_W'(LOAD_CYCLES)) begin
                    load_d  = 1'b0;
                    ready_d = 1'b1;
                    lcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    lcnt_d = lcnt_q + LC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            load_q   <= 1'b0;
            errc_q   <= 1'b0;
            errt_q   <= 1'b0;
            fcnt_q   <= 8'h00;
            csum_q   <= 8'h00;
            idx_q    <= '0;
            to_q     <= '0;
            lcnt_q   <= '0;
            shadow_q <= '0;
            re_q     <= '0;
            im_q     <= '0;
            pw_q     <= '0;
            ar_q     <= '0;
            ai_q     <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            load_q   <= load_d;
            errc_q   <= errc_d;
            errt_q   <= errt_d;
            fcnt_q   <= fcnt_d;
            csum_q   <= csum_d;
            idx_q    <= idx_d;
            to_q     <= to_d;
            lcnt_q   <= lcnt_d;
            shadow_q <= shadow_d;
            re_q     <= re_d;
            im_q     <= im_d;
            pw_q     <= pw_d;
            ar_q     <= ar_d;
            ai_q     <= ai_d;
        end
    end

    assign data_ready   = ready_q;
    assign load         = load_q;
    assign err_checksum = errc_q;
    assign err_timeout  = errt_q;
    assign frame_cnt    = fcnt_q;
    assign re_coeff     = re_q;
    assign im_coeff     = im_q;
    assign power        = pw_q;
    assign accu_re_init = ar_q;
    assign accu_im_init = ai_q;

endmodule

// File: tb/tb_qosc_config_loader.sv
// Scoreboard bench for qosc_config_loader: frame-level model pushes expected commits,
// a monitor pops them whenever load rises and checks the whole strobe window.
module tb_qosc_config_loader;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned TIMEOUT     = 1023;
    localparam int unsigned LOAD_CYCLES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             data_ready;
    logic [WIDTH-1:0] re_coeff, im_coeff, power, accu_re_init, accu_im_init;
    logic             load, err_checksum, err_timeout;
    logic [7:0]       frame_cnt;
    logic [79:0]      dut_words;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [87:0] sb[$];
    logic [79:0] model_words;
    logic [7:0]  model_cnt;

    qosc_config_loader #(
        .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .LOAD_CYCLES(LOAD_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .re_coeff(re_coeff), .im_coeff(im_coeff),
        .power(power), .accu_re_init(accu_re_init), .accu_im_init(accu_im_init),
        .load(load), .err_checksum(err_checksum), .err_timeout(err_timeout),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    assign dut_words = {re_coeff, im_coeff, power, accu_re_init, accu_im_init};

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [79:0] p);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 10; i++) s = s ^ p[8*i +: 8];
        return s;
    endfunction

    task automatic idle(input int n);
        data_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Present a byte (valid held high) until the loader is ready; accepted on the following posedge
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        data_in    = b;
        data_valid = 1'b1;
        while (!data_ready) begin
            @(negedge clk);
            t++;
            if (t > 64) begin
                check("ready_wait_expired", 80'(1), 80'(0));
                break;
            end
        end
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [79:0] p, input logic [7:0] chk,
                              input bit gaps, input int stall3);
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) begin
            if (i == 3 && stall3 > 0) begin
                idle(stall3);
                if (stall3 >= int'(TIMEOUT)) begin
                    check("timeout_flag", 80'(err_timeout), 80'(1));
                    check("timeout_no_load", 80'(load), 80'(0));
                    check("timeout_ready", 80'(data_ready), 80'(1));
                    check("timeout_cnt", 80'(frame_cnt), 80'(model_cnt));
                    check("timeout_words", dut_words, model_words);
                    return;
                end
                check("no_timeout_flag", 80'(err_timeout), 80'(0));
            end else if (gaps) begin
                idle($urandom_range(0, 3));
            end
            send_byte(p[79-8*i -: 8]);
        end
        if (chk == xsum(p)) begin
            model_cnt   = model_cnt + 8'd1;
            model_words = p;
            sb.push_back({p, model_cnt});
            send_byte(chk);
        end else begin
            send_byte(chk);
            check("bad_chk_flag", 80'(err_checksum), 80'(1));
            check("bad_chk_no_load", 80'(load), 80'(0));
            check("bad_chk_cnt", 80'(frame_cnt), 80'(model_cnt));
            check("bad_chk_words", dut_words, model_words);
        end
    endtask

    task automatic pulse_reset();
        rst        = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'($urandom);
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        data_valid  = 1'b0;
        model_cnt   = 8'h00;
        model_words = '0;
        sb.delete();
    endtask

    function automatic logic [79:0] rand_payload();
        return {32'($urandom), 32'($urandom), 16'($urandom)};
    endfunction

    // Monitor: every load pulse must match the next expected commit and last LOAD_CYCLES cycles
    int          load_len = 0;
    logic        load_prev = 1'b0;
    logic [87:0] cur = '0;
    always @(negedge clk) begin
        if (rst) begin
            load_prev = 1'b0;
            load_len  = 0;
        end else begin
            if (load && !load_prev) begin
                load_len = 0;
                if (sb.size() == 0) check("unexpected_load", 80'(1), 80'(0));
                else cur = sb.pop_front();
                check("commit_err_checksum", 80'(err_checksum), 80'(0));
                check("commit_err_timeout", 80'(err_timeout), 80'(0));
            end
            if (load) begin
                load_len++;
                check("load_words", dut_words, cur[87:8]);
                check("load_frame_cnt", 80'(frame_cnt), 80'(cur[7:0]));
                check("ready_during_load", 80'(data_ready), 80'(0));
            end
            if (!load && load_prev) check("load_len", 80'(load_len), 80'(LOAD_CYCLES));
            load_prev = load;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] p;
        logic [7:0]  chk;
        rst         = 1'b1;
        data_valid  = 1'b0;
        data_in     = 8'h00;
        model_cnt   = 8'h00;
        model_words = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 80'(data_ready), 80'(1));
        check("rst_load", 80'(load), 80'(0));
        check("rst_errc", 80'(err_checksum), 80'(0));
        check("rst_errt", 80'(err_timeout), 80'(0));
        check("rst_cnt", 80'(frame_cnt), 80'(0));
        check("rst_words", dut_words, 80'(0));
        rst = 1'b0;
        @(negedge clk);

        // Directed frame; XOR of the payload bytes is 0x90
        send_frame(80'h4000_0040_1000_7FFF_0000, 8'h90, 1'b0, 0);
        idle(8);
        check("dir_words", dut_words, 80'h4000_0040_1000_7FFF_0000);
        check("dir_cnt", 80'(frame_cnt), 80'(1));

        // Same frame with a wrong checksum, then a good frame clears the flag
        send_frame(80'h4000_0040_1000_7FFF_0000, 8'h00, 1'b0, 0);
        p = rand_payload();
        send_frame(p, xsum(p), 1'b0, 0);
        idle(8);
        check("recover_errc", 80'(err_checksum), 80'(0));
        check("recover_cnt", 80'(frame_cnt), 80'(model_cnt));

        // Inter-byte timeout, then a byte arriving on the last allowed cycle
        p = rand_payload();
        send_frame(p, xsum(p), 1'b0, int'(TIMEOUT));
        p = rand_payload();
        send_frame(p, xsum(p), 1'b0, int'(TIMEOUT) - 1);
        idle(8);
        check("edge_timeout_cnt", 80'(frame_cnt), 80'(model_cnt));

        // Junk before the header, 0xA5 inside the payload
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        p = rand_payload();
        p[55:48] = 8'hA5;
        send_frame(p, xsum(p), 1'b0, 0);
        idle(8);
        check("a5_payload_words", dut_words, p);

        // Reset in the middle of a frame
        send_byte(8'hA5);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        pulse_reset();
        check("midrst_words", dut_words, 80'(0));
        check("midrst_cnt", 80'(frame_cnt), 80'(0));
        check("midrst_ready", 80'(data_ready), 80'(1));
        check("midrst_load", 80'(load), 80'(0));
        p = rand_payload();
        send_frame(p, xsum(p), 1'b0, 0);

        // Random frames with gaps and occasional corrupted checksums
        for (int n = 0; n < 24; n++) begin
            p   = rand_payload();
            chk = xsum(p);
            if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            send_frame(p, chk, 1'b1, 0);
        end
        idle(8);
        check("rand_cnt", 80'(frame_cnt), 80'(model_cnt));

        // 256 back-to-back frames wrap the commit counter
        pulse_reset();
        for (int n = 0; n < 256; n++) begin
            p = rand_payload();
            send_frame(p, xsum(p), 1'b0, 0);
        end
        idle(8);
        check("wrap_cnt", 80'(frame_cnt), 80'(0));
        check("wrap_words", dut_words, model_words);
        check("sb_drained", 80'(sb.size()), 80'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
